// File: rtl/pdp8_tty.sv
// pdp8_tty: KL8E-style console teletype IOT responder.
// Keyboard (KBD_DEV) and printer (TTY_DEV) IOTs are decoded from the CPU's
// programmed-I/O bus. Skip and AC-load responses are combinational for the
// whole IOT window. State changes happen once per IOT, on its first cycle.
// Optional macro PDP8_TTY_IE_EN adds an interrupt-enable bit, written by KIE (6035).
//
// Printer FSM:
//   state  | meaning
//   P_IDLE | no character in flight, print IOTs accepted
//   P_SEND | tx_valid high, holding tx_data until the sink takes it
//   P_WAIT | byte taken, counting down the character time before tty_flag
module pdp8_tty #(
    parameter logic [5:0] KBD_DEV    = 6'o03,
    parameter logic [5:0] TTY_DEV    = 6'o04,
    parameter int         CHAR_DELAY = 16,
    parameter int         DELAY_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iot,
    input  logic [5:0]  io_select,
    input  logic [11:0] mb,
    input  logic [11:0] io_data_in,
    output logic [11:0] io_data_out,
    output logic        io_data_avail,
    output logic        io_skip,
    output logic        io_interrupt,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_SEND = 2'd1,
        P_WAIT = 2'd2
    } pstate_t;

    localparam logic [DELAY_W-1:0] DELAY_LOAD = DELAY_W'(CHAR_DELAY - 1);

    logic               iot_q;
    logic               kbd_flag_q, kbd_flag_d;
    logic [7:0]         kbd_buf_q,  kbd_buf_d;
    logic               tty_flag_q, tty_flag_d;
    pstate_t            pstate_q,   pstate_d;
    logic [7:0]         tx_data_q,  tx_data_d;
    logic [DELAY_W-1:0] cnt_q,      cnt_d;
    logic               irq_q,      irq_d;

    logic [2:0] fn;
    logic       sel_k, sel_t, commit, commit_k, commit_t, print_req;
    // Opcode and device bits of mb are carried by io_select; only the IOP bits are needed here.
    logic       unused_mb;

    assign fn        = mb[2:0];
    assign unused_mb = ^mb[11:3];
    assign sel_k     = iot && (io_select == KBD_DEV);
    assign sel_t     = iot && (io_select == TTY_DEV);
    assign commit    = iot && !iot_q;
    assign commit_k  = commit && sel_k;
    assign commit_t  = commit && sel_t;
    assign print_req = commit_t && ((fn == 3'd4) || (fn == 3'd6));

    // Combinational skip / AC-load responses, held for the whole IOT window
    always_comb begin
        io_skip       = 1'b0;
        io_data_avail = 1'b0;
        io_data_out   = '0;
        if (sel_k) begin
            case (fn)
                3'd1: io_skip = kbd_flag_q;
                3'd2: io_data_avail = 1'b1;
                3'd4: begin
                    io_data_avail = 1'b1;
                    io_data_out   = io_data_in | {4'b0, kbd_buf_q};
                end
                3'd6: begin
                    io_data_avail = 1'b1;
                    io_data_out   = {4'b0, kbd_buf_q};
                end
                default: ;
            endcase
        end else if (sel_t && (fn == 3'd1)) begin
            io_skip = tty_flag_q;
        end
    end

    // Keyboard buffer and flag; an arriving byte beats a same-cycle flag clear
    always_comb begin
        kbd_flag_d = kbd_flag_q;
        kbd_buf_d  = kbd_buf_q;
        if (commit_k && ((fn == 3'd0) || (fn == 3'd2) || (fn == 3'd6)))
            kbd_flag_d = 1'b0;
        if (rx_valid) begin
            kbd_flag_d = 1'b1;
            kbd_buf_d  = rx_data;
        end
    end

    // Printer FSM next state and tty_flag; an IOT flag write beats the FSM's flag set
    always_comb begin
        pstate_d   = pstate_q;
        tx_data_d  = tx_data_q;
        cnt_d      = cnt_q;
        tty_flag_d = tty_flag_q;
        case (pstate_q)
            P_IDLE: begin
                if (print_req) begin
                    tx_data_d = io_data_in[7:0];
                    pstate_d  = P_SEND;
                end
            end
            P_SEND: begin
                if (tx_ready) begin
                    cnt_d    = DELAY_LOAD;
                    pstate_d = P_WAIT;
                end
            end
            P_WAIT: begin
                if (cnt_q == '0) begin
                    tty_flag_d = 1'b1;
                    pstate_d   = P_IDLE;
                end else begin
                    cnt_d = cnt_q - DELAY_W'(1);
                end
            end
            default: pstate_d = P_IDLE;
        endcase
        if (commit_t) begin
            case (fn)
                3'd0:       tty_flag_d = 1'b1;
                3'd2, 3'd6: tty_flag_d = 1'b0;
                default: ;
            endcase
        end
    end

`ifdef PDP8_TTY_IE_EN
    logic int_en_q, int_en_d;

    // Interrupt enable (KIE loads AC bit 0) and gated interrupt request
    always_comb begin
        int_en_d = int_en_q;
        if (commit_k && (fn == 3'd5))
            int_en_d = io_data_in[0];
        irq_d = int_en_d && (kbd_flag_d || tty_flag_d);
    end

    // Interrupt enable register; enabled out of reset
    always_ff @(posedge clk) begin
        if (!reset) int_en_q <= 1'b1;
        else        int_en_q <= int_en_d;
    end
`else
    // Interrupt request follows the flags directly
    always_comb begin
        irq_d = kbd_flag_d || tty_flag_d;
    end
`endif

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            iot_q      <= 1'b0;
            kbd_flag_q <= 1'b0;
            kbd_buf_q  <= '0;
            tty_flag_q <= 1'b0;
            pstate_q   <= P_IDLE;
            tx_data_q  <= '0;
            cnt_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            iot_q      <= iot;
            kbd_flag_q <= kbd_flag_d;
            kbd_buf_q  <= kbd_buf_d;
            tty_flag_q <= tty_flag_d;
            pstate_q   <= pstate_d;
            tx_data_q  <= tx_data_d;
            cnt_q      <= cnt_d;
            irq_q      <= irq_d;
        end
    end

    assign tx_valid     = (pstate_q == P_SEND);
    assign tx_data      = tx_data_q;
    assign io_interrupt = irq_q;

endmodule

// File: tb/tb_pdp8_tty.sv
// Bench for pdp8_tty: directed test-plan steps followed by random IOT traffic,
// every cycle compared against a transaction-level model of the teletype.
module tb_pdp8_tty;
    localparam int CHAR_DELAY = 16;
`ifdef PDP8_TTY_IE_EN
    localparam bit IE = 1'b1;
`else
    localparam bit IE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, iot, rx_valid, tx_ready;
    logic [5:0]  io_select;
    logic [11:0] mb, io_data_in;
    logic [11:0] io_data_out;
    logic        io_data_avail, io_skip, io_interrupt, tx_valid;
    logic [7:0]  rx_data, tx_data;

    always #5 clk = ~clk;

    pdp8_tty #(.KBD_DEV(6'o03), .TTY_DEV(6'o04), .CHAR_DELAY(CHAR_DELAY), .DELAY_W(8)) dut (
        .clk(clk), .reset(reset), .iot(iot), .io_select(io_select), .mb(mb),
        .io_data_in(io_data_in), .io_data_out(io_data_out), .io_data_avail(io_data_avail),
        .io_skip(io_skip), .io_interrupt(io_interrupt), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready)
    );

    int checks = 0;
    int errors = 0;

    // reference model: flags, buffers, printer as "sending" / "waiting until cycle"
    bit         m_known = 1'b0;
    logic       m_kflag, m_tflag, m_en, m_irq, m_sending, m_waiting, m_iot_prev;
    logic [7:0] m_kbuf, m_txbyte;
    int         m_due;
    int         cyc = 0;

    logic        cap_skip, cap_avail, f_skip, f_avail;
    logic [11:0] cap_data, f_data;
    int          txv_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: check outputs at negedge, advance model, return at posedge+1
    task automatic tick();
        logic        selk, selt, commit, e_skip, e_avail;
        logic [2:0]  f;
        logic [11:0] e_data;
        logic        n_k, n_t, n_s, n_w, n_en;
        logic [7:0]  n_kb, n_tx;
        int          n_due;
        @(negedge clk);
        f      = mb[2:0];
        selk   = iot && (io_select == 6'o03);
        selt   = iot && (io_select == 6'o04);
        e_skip  = 1'b0;
        e_avail = 1'b0;
        e_data  = 12'o0;
        if (m_known) begin
            if (selk && f == 3'd1) e_skip = m_kflag;
            if (selt && f == 3'd1) e_skip = m_tflag;
            if (selk && f == 3'd2) e_avail = 1'b1;
            if (selk && f == 3'd4) begin e_avail = 1'b1; e_data = io_data_in | {4'b0, m_kbuf}; end
            if (selk && f == 3'd6) begin e_avail = 1'b1; e_data = {4'b0, m_kbuf}; end
            chk("io_skip", io_skip, e_skip);
            chk("io_data_avail", io_data_avail, e_avail);
            chk("io_data_out", io_data_out, e_data);
            chk("tx_valid", tx_valid, m_sending);
            chk("tx_data", tx_data, m_txbyte);
            chk("io_interrupt", io_interrupt, m_irq);
        end
        cap_skip  = io_skip;
        cap_avail = io_data_avail;
        cap_data  = io_data_out;
        if (tx_valid === 1'b1) txv_cnt++;

        commit = iot && !m_iot_prev;
        if (!reset) begin
            m_known = 1'b1;
            m_kflag = 0; m_tflag = 0; m_kbuf = 0; m_txbyte = 0;
            m_sending = 0; m_waiting = 0; m_en = 1; m_irq = 0; m_iot_prev = 0; m_due = 0;
        end else if (m_known) begin
            n_k = m_kflag; n_kb = m_kbuf;
            if (commit && selk && (f == 3'd0 || f == 3'd2 || f == 3'd6)) n_k = 1'b0;
            if (rx_valid) begin n_k = 1'b1; n_kb = rx_data; end
            n_t = m_tflag; n_s = m_sending; n_w = m_waiting; n_tx = m_txbyte; n_due = m_due;
            if (!m_sending && !m_waiting) begin
                if (commit && selt && (f == 3'd4 || f == 3'd6)) begin n_s = 1'b1; n_tx = io_data_in[7:0]; end
            end else if (m_sending) begin
                if (tx_ready) begin n_s = 1'b0; n_w = 1'b1; n_due = cyc + CHAR_DELAY; end
            end else if (cyc == m_due) begin
                n_w = 1'b0; n_t = 1'b1;
            end
            if (commit && selt && f == 3'd0) n_t = 1'b1;
            if (commit && selt && (f == 3'd2 || f == 3'd6)) n_t = 1'b0;
            n_en = m_en;
            if (IE && commit && selk && f == 3'd5) n_en = io_data_in[0];
            m_kflag = n_k; m_kbuf = n_kb; m_tflag = n_t; m_sending = n_s; m_waiting = n_w;
            m_txbyte = n_tx; m_due = n_due; m_en = n_en;
            m_irq = (IE ? n_en : 1'b1) && (n_k || n_t);
            m_iot_prev = iot;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_iot(input logic [5:0] dev, input logic [2:0] f, input logic [11:0] ac, input int n);
        iot = 1'b1; io_select = dev; mb = {3'o6, dev, f}; io_data_in = ac;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0) begin f_skip = cap_skip; f_avail = cap_avail; f_data = cap_data; end
        end
        iot = 1'b0; io_select = 6'o0; mb = 12'o0; io_data_in = 12'o0;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout reached before end of test");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b1; iot = 1'b0; io_select = 6'o0; mb = 12'o0; io_data_in = 12'o0;
        rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
        @(posedge clk); #1;

        // 1: reset with rx_valid active
        reset = 1'b0; rx_valid = 1'b1; rx_data = 8'h55;
        repeat (3) tick();
        chk("t1_rst_txvalid", tx_valid, 1'b0);
        chk("t1_rst_irq", io_interrupt, 1'b0);
        chk("t1_rst_txdata", tx_data, 8'h00);
        reset = 1'b1; rx_valid = 1'b0;
        do_iot(6'o03, 3'd1, 12'o0, 1);
        chk("t1_ksf_skip", f_skip, 1'b0);

        // 2: receive 'A', KSF, KRB
        rx_valid = 1'b1; rx_data = 8'h41; tick(); rx_valid = 1'b0; tick();
        chk("t2_irq_rise", io_interrupt, 1'b1);
        do_iot(6'o03, 3'd1, 12'o0, 1);
        chk("t2_ksf_skip", f_skip, 1'b1);
        do_iot(6'o03, 3'd6, 12'o7777, 1);
        chk("t2_krb_avail", f_avail, 1'b1);
        chk("t2_krb_data", f_data, 12'o0101);
        chk("t2_irq_fall", io_interrupt, 1'b0);
        do_iot(6'o03, 3'd1, 12'o0, 1);
        chk("t2_ksf_after", f_skip, 1'b0);

        // 3: TLS with stalled sink
        do_iot(6'o04, 3'd6, 12'o0215, 1);
        chk("t3_txvalid", tx_valid, 1'b1);
        chk("t3_txdata", tx_data, 8'h8D);
        repeat (5) tick();
        chk("t3_hold_data", tx_data, 8'h8D);
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        chk("t3_hs_txvalid", tx_valid, 1'b0);
        // 4: TPC during WAIT is dropped
        do_iot(6'o04, 3'd4, 12'o0101, 1);
        n = 2;
        chk("t4_tpc_dropped", tx_valid, 1'b0);
        while (io_interrupt !== 1'b1 && n < 40) begin tick(); n++; end
        chk("t3_char_delay", n, CHAR_DELAY);
        do_iot(6'o04, 3'd1, 12'o0, 1);
        chk("t3_tsf_skip", f_skip, 1'b1);
        rx_valid = 1'b1; rx_data = 8'h0A; tick(); rx_valid = 1'b0;
        do_iot(6'o03, 3'd4, 12'o7400, 1);
        chk("t4_krs_data", f_data, 12'o7412);

        // 5: KCC racing a received byte; long IOT window
        iot = 1'b1; io_select = 6'o03; mb = 12'o6032; io_data_in = 12'o1234;
        rx_valid = 1'b1; rx_data = 8'h33;
        tick();
        chk("t5_kcc_avail", cap_avail, 1'b1);
        chk("t5_kcc_data", cap_data, 12'o0);
        rx_valid = 1'b0; iot = 1'b0; io_select = 6'o0; mb = 12'o0; tick();
        do_iot(6'o03, 3'd1, 12'o0, 1);
        chk("t5_kflag_set", f_skip, 1'b1);
        do_iot(6'o03, 3'd4, 12'o0, 1);
        chk("t5_kbuf", f_data, 12'h033);
        txv_cnt = 0; tx_ready = 1'b1;
        do_iot(6'o04, 3'd6, 12'o0123, 3);
        repeat (2) tick();
        tx_ready = 1'b0;
        chk("t5_single_commit", txv_cnt, 1);
        repeat (CHAR_DELAY + 2) tick();

`ifdef PDP8_TTY_IE_EN
        // 6: interrupt enable
        do_iot(6'o03, 3'd0, 12'o0, 1);
        do_iot(6'o04, 3'd2, 12'o0, 1);
        do_iot(6'o03, 3'd5, 12'o0, 1);
        rx_valid = 1'b1; rx_data = 8'h21; tick(); rx_valid = 1'b0; tick();
        chk("t6_irq_masked", io_interrupt, 1'b0);
        do_iot(6'o03, 3'd1, 12'o0, 1);
        chk("t6_ksf_skip", f_skip, 1'b1);
        iot = 1'b1; io_select = 6'o03; mb = 12'o6035; io_data_in = 12'o0001;
        tick();
        chk("t6_irq_enabled", io_interrupt, 1'b1);
        iot = 1'b0; io_select = 6'o0; mb = 12'o0; io_data_in = 12'o0; tick();
`endif

        // random traffic
        for (int it = 0; it < 500; it++) begin
            int sel, len;
            logic [5:0] dev;
            sel = $urandom_range(0, 4);
            len = $urandom_range(1, 3);
            dev = (sel == 0 || sel == 3) ? 6'o03 : (sel == 1 || sel == 4) ? 6'o04 : 6'($urandom_range(0, 63));
            iot = (sel != 2) || ($urandom_range(0, 1) == 1);
            io_select = dev;
            mb = {3'o6, dev, 3'($urandom_range(0, 7))};
            io_data_in = 12'($urandom);
            for (int c = 0; c < len; c++) begin
                rx_valid = ($urandom_range(0, 9) == 0);
                rx_data  = 8'($urandom);
                tx_ready = ($urandom_range(0, 1) == 1);
                reset    = ($urandom_range(0, 199) != 0);
                tick();
            end
            iot = 1'b0; io_select = 6'o0; mb = 12'o0; reset = 1'b1;
            for (int g = 0; g < int'($urandom_range(1, 4)); g++) begin
                rx_valid = ($urandom_range(0, 9) == 0);
                rx_data  = 8'($urandom);
                tx_ready = ($urandom_range(0, 1) == 1);
                tick();
            end
        end
        rx_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
